wb_retire_buf: RTL and testbench
================================

WB_RETIRE_BUF -- requirements
Module: wb_retire_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning GPR/CSR data and PC width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning GPR address width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning retire-buffer entries; legal values are powers of two >= 2.
REQ-004 SHALL have port clk, input, 1, the single clock; resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, MEM-stage entry valid; in_allowin, output, 1, buffer accepts this cycle.
REQ-006 SHALL have in_pc, input, DATA_W, entry PC; in_gr_we, input, 1, GPR write request; in_dest, input, REG_AW, GPR index; in_result, input, DATA_W, ALU/load result.
REQ-007 SHALL have in_csr_re, input, 1, CSR read request; in_csr_we, input, 1, CSR write request; in_csr_num, input, 14, CSR index; in_csr_wmask, input, DATA_W, write mask; in_csr_wvalue, input, DATA_W, write value.
REQ-008 SHALL have in_ex, input, 3, exception flags {ine, brk, sys}; in_ertn, input, 1, ertn instruction.
REQ-009 SHALL have rf_stall, input, 1, hold retirement this cycle.
REQ-010 SHALL have csr_re, output, 1; csr_num, output, 14; csr_rvalue, input, DATA_W; csr_we, output, 1; csr_wmask, output, DATA_W; csr_wvalue, output, DATA_W.
REQ-011 SHALL have rf_we, output, 1; rf_waddr, output, REG_AW; rf_wdata, output, DATA_W, GPR write port.
REQ-012 SHALL have wb_ex, output, 1; ertn_flush, output, 1; wb_pc, output, DATA_W; wb_ecode, output, 6; wb_esubcode, output, 9.
REQ-013 SHALL have occupancy, output, $clog2(DEPTH)+1, valid entry count; debug_wb_pc, output, 32; debug_wb_rf_we, output, 4; debug_wb_rf_wnum, output, 5; debug_wb_rf_wdata, output, 32.

Function
REQ-014 SHALL hold entries in a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 SHALL push on in_valid && in_allowin, writing all in_* fields at the tail.
REQ-016 SHALL define retire = (occupancy != 0) && !rf_stall; retire pops the head entry in the same cycle its outputs are driven.
REQ-017 SHALL drive in_allowin = (occupancy < DEPTH) || retire, so push and pop together when full are legal.
REQ-018 SHALL update occupancy by +1 on push only, -1 on pop only, and leave it unchanged on push and pop together.
REQ-019 SHALL gate every side effect with retire: rf_we, csr_re, csr_we, wb_ex and ertn_flush are 0 when retire is 0.
REQ-020 SHALL set head_exc = |head.ex; wb_ex = retire && head_exc.
REQ-021 SHALL set ertn_flush = retire && head.ertn && !head_exc.
REQ-022 SHALL suppress rf_we, csr_we and csr_re for an excepting head entry.
REQ-023 SHALL drive wb_ecode with priority sys=0x0B, then brk=0x0C, then ine=0x0D, and 0 when wb_ex=0.
REQ-024 SHALL drive wb_esubcode = 0.
REQ-025 SHALL drive wb_pc = head.pc.
REQ-026 SHALL drive rf_wdata = csr_rvalue when head.csr_re, else head.result; rf_waddr = head.dest.
REQ-027 SHALL, on wb_ex or ertn_flush, pop the head and clear all other entries at the next edge: occupancy becomes 0 and head equals tail.
REQ-028 SHALL discard any push coinciding with a flush cycle.
REQ-029 SHALL mirror retired values onto the debug outputs: debug_wb_pc = head.pc, debug_wb_rf_we = {4{rf_we}}, wnum = rf_waddr, wdata = rf_wdata; extra bits are zero-extended or truncated to 32/5.
REQ-030 SHALL add zero-cycle latency from head to outputs; an entry retires no earlier than one cycle after its push.
REQ-031 SHALL retire back-to-back entries at one per cycle when unstalled.

Reset
REQ-032 SHALL, while resetn=0 (asynchronous), force occupancy=0, head=tail=0, and all side-effect outputs (rf_we, csr_re, csr_we, wb_ex, ertn_flush) to 0.
REQ-033 SHALL leave entry payload storage without reset.
REQ-034 SHALL discard in-flight entries when reset is asserted mid-operation; in_allowin=1 on the first cycle after release.

Structure
REQ-035 SHALL take the ecode constants (ECODE_SYS, ECODE_BRK, ECODE_INE) and the entry field layout from the shared CPU package or defines file.
REQ-036 SHALL use one natural sub-module, wb_entry_fifo, a parametrised circular buffer with push/pop/clear and occupancy; priority and CSR muxing stay in the top level.

Verification
REQ-037 SHALL cover: push {pc=0x1c000000, gr_we=1, dest=4, result=0x55} -> next cycle rf_we=1, waddr=4, wdata=0x55, occupancy 1->0.
REQ-038 SHALL cover: DEPTH=2, rf_stall=1, three pushes attempted -> two accepted, in_allowin=0, occupancy=2; release stall -> retires in order, one per cycle.
REQ-039 SHALL cover: full buffer, push and retire in the same cycle -> occupancy stays at DEPTH, tail pointer wraps, FIFO order preserved.
REQ-040 SHALL cover: head ex=3'b011 (sys+brk) with a younger entry queued -> wb_ex=1, wb_ecode=0x0B, rf_we=0, next cycle occupancy=0.
REQ-041 SHALL cover: head ertn with a coincident push -> ertn_flush=1 for one cycle, pushed entry discarded, occupancy=0.
REQ-042 SHALL cover: head csr_re=1, csr_rvalue=0xABCD, dest=7 -> rf_wdata=0xABCD; resetn pulsed low mid-stream -> occupancy=0 asynchronously.

Source files
------------

// File: rtl/wb_retire_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_retire_buf_pkg
//  Description : Shared definitions for the write-back retire buffer:
//                exception codes, exception flag bit positions and the
//                fixed-width control part of a buffered entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_retire_buf_pkg;

    localparam int CSR_NUM_W  = 14;
    localparam int EX_W       = 3;
    localparam int ECODE_W    = 6;
    localparam int ESUBCODE_W = 9;

    // Bit positions inside the {ine, brk, sys} exception flag vector
    localparam int EX_SYS = 0;
    localparam int EX_BRK = 1;
    localparam int EX_INE = 2;

    localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

    // Control fields of one entry; the data-width-dependent fields
    // (pc, result, csr mask/value, dest) are concatenated around this
    // in the top level because they depend on module parameters.
    typedef struct packed {
        logic                 gr_we;
        logic                 csr_re;
        logic                 csr_we;
        logic                 ertn;
        logic [EX_W-1:0]      ex;
        logic [CSR_NUM_W-1:0] csr_num;
    } entry_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/wb_entry_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_entry_fifo
//  Description : Parametrised circular buffer with push, pop, clear and an
//                occupancy count. The head entry is visible combinationally
//                on rdata. Payload storage carries no reset.
//  Ports       : clk, resetn (async, active low)
//                push/wdata   - write at tail
//                pop          - advance head
//                clear        - empty the buffer; a coincident push is dropped
//                rdata        - head entry
//                occupancy    - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_entry_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] occ_q,  occ_d;
    logic             wr_en;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        wr_en  = push && !clear;
        if (clear) begin
            // Collapse to empty by moving head onto the current tail
            head_d = tail_q;
            occ_d  = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_W'(1);
                2'b01:   occ_d = occ_q - CNT_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[tail_q] <= wdata;
    end

    assign rdata     = mem_q[head_q];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: rtl/wb_retire_buf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_retire_buf
//  Description : Write-back retire buffer. Queues MEM-stage results and
//                retires the oldest one per unstalled cycle, driving GPR,
//                CSR, exception and debug outputs straight from the head.
//                An excepting or ertn head flushes every younger entry.
//  Ports       : clk, resetn (async, active low)
//                in_*          - incoming entry, handshake in_valid/in_allowin
//                rf_stall      - hold retirement
//                csr_*         - CSR read/write port (csr_rvalue returns data)
//                rf_*          - GPR write port
//                wb_*, ertn_flush - exception / return signalling
//                occupancy     - valid entry count
//                debug_wb_*    - retired-instruction trace
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_retire_buf
    import wb_retire_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_allowin,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic                   in_gr_we,
    input  logic [REG_AW-1:0]      in_dest,
    input  logic [DATA_W-1:0]      in_result,
    input  logic                   in_csr_re,
    input  logic                   in_csr_we,
    input  logic [13:0]            in_csr_num,
    input  logic [DATA_W-1:0]      in_csr_wmask,
    input  logic [DATA_W-1:0]      in_csr_wvalue,
    input  logic [2:0]             in_ex,
    input  logic                   in_ertn,
    input  logic                   rf_stall,
    output logic                   csr_re,
    output logic [13:0]            csr_num,
    input  logic [DATA_W-1:0]      csr_rvalue,
    output logic                   csr_we,
    output logic [DATA_W-1:0]      csr_wmask,
    output logic [DATA_W-1:0]      csr_wvalue,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   wb_ex,
    output logic                   ertn_flush,
    output logic [DATA_W-1:0]      wb_pc,
    output logic [5:0]             wb_ecode,
    output logic [8:0]             wb_esubcode,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_we,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int CTRL_W   = $bits(entry_ctrl_t);
    localparam int ENTRY_W  = 4 * DATA_W + REG_AW + CTRL_W;
    // Widen-then-slice gives zero-extension or truncation onto the
    // fixed-width debug ports for any DATA_W / REG_AW.
    localparam int DBG_DW   = (DATA_W > 32) ? DATA_W : 32;
    localparam int DBG_AW   = (REG_AW > 5)  ? REG_AW : 5;

    entry_ctrl_t        in_ctrl;
    entry_ctrl_t        head_ctrl;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [DATA_W-1:0]  head_pc;
    logic [DATA_W-1:0]  head_result;
    logic [DATA_W-1:0]  head_wmask;
    logic [DATA_W-1:0]  head_wvalue;
    logic [REG_AW-1:0]  head_dest;

    logic               retire;
    logic               head_exc;
    logic               flush;
    logic               push;
    logic [DBG_DW-1:0]  dbg_pc_ext;
    logic [DBG_DW-1:0]  dbg_wdata_ext;
    logic [DBG_AW-1:0]  dbg_wnum_ext;

    always_comb begin
        in_ctrl         = '0;
        in_ctrl.gr_we   = in_gr_we;
        in_ctrl.csr_re  = in_csr_re;
        in_ctrl.csr_we  = in_csr_we;
        in_ctrl.ertn    = in_ertn;
        in_ctrl.ex      = in_ex;
        in_ctrl.csr_num = in_csr_num;
    end

    assign push_entry = {in_pc, in_result, in_csr_wmask, in_csr_wvalue, in_dest, in_ctrl};
    assign {head_pc, head_result, head_wmask, head_wvalue, head_dest, head_ctrl} = head_entry;

    assign retire     = (occupancy != '0) && !rf_stall;
    assign in_allowin = (occupancy != CNT_W'(DEPTH)) || retire;
    assign push       = in_valid && in_allowin;
    assign head_exc   = |head_ctrl.ex;
    assign flush      = wb_ex || ertn_flush;

    wb_entry_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (retire),
        .clear     (flush),
        .wdata     (push_entry),
        .rdata     (head_entry),
        .occupancy (occupancy)
    );

    always_comb begin
        rf_we       = retire && head_ctrl.gr_we  && !head_exc;
        csr_re      = retire && head_ctrl.csr_re && !head_exc;
        csr_we      = retire && head_ctrl.csr_we && !head_exc;
        wb_ex       = retire && head_exc;
        ertn_flush  = retire && head_ctrl.ertn && !head_exc;
        csr_num     = head_ctrl.csr_num;
        csr_wmask   = head_wmask;
        csr_wvalue  = head_wvalue;
        rf_waddr    = head_dest;
        rf_wdata    = head_ctrl.csr_re ? csr_rvalue : head_result;
        wb_pc       = head_pc;
        wb_esubcode = '0;
        wb_ecode    = '0;
        if (wb_ex) begin
            if (head_ctrl.ex[EX_SYS])      wb_ecode = ECODE_SYS;
            else if (head_ctrl.ex[EX_BRK]) wb_ecode = ECODE_BRK;
            else                           wb_ecode = ECODE_INE;
        end
    end

    assign dbg_pc_ext        = DBG_DW'(head_pc);
    assign dbg_wdata_ext     = DBG_DW'(rf_wdata);
    assign dbg_wnum_ext      = DBG_AW'(head_dest);
    assign debug_wb_pc       = dbg_pc_ext[31:0];
    assign debug_wb_rf_wdata = dbg_wdata_ext[31:0];
    assign debug_wb_rf_wnum  = dbg_wnum_ext[4:0];
    assign debug_wb_rf_we    = {4{rf_we}};

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_retire_buf
//  Description : Randomised and directed bench for wb_retire_buf against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_retire_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_allowin;
    logic [31:0] in_pc;
    logic        in_gr_we;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        in_csr_re;
    logic        in_csr_we;
    logic [13:0] in_csr_num;
    logic [31:0] in_csr_wmask;
    logic [31:0] in_csr_wvalue;
    logic [2:0]  in_ex;
    logic        in_ertn;
    logic        rf_stall;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [1:0]  occupancy;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_retire_buf #(
        .DATA_W (32),
        .REG_AW (5),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_allowin        (in_allowin),
        .in_pc             (in_pc),
        .in_gr_we          (in_gr_we),
        .in_dest           (in_dest),
        .in_result         (in_result),
        .in_csr_re         (in_csr_re),
        .in_csr_we         (in_csr_we),
        .in_csr_num        (in_csr_num),
        .in_csr_wmask      (in_csr_wmask),
        .in_csr_wvalue     (in_csr_wvalue),
        .in_ex             (in_ex),
        .in_ertn           (in_ertn),
        .rf_stall          (rf_stall),
        .csr_re            (csr_re),
        .csr_num           (csr_num),
        .csr_rvalue        (csr_rvalue),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wvalue        (csr_wvalue),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .wb_pc             (wb_pc),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .occupancy         (occupancy),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic [2:0]  ex;
        logic        ertn;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = '0; in_gr_we = 0; in_dest = '0; in_result = '0;
        in_csr_re = 0; in_csr_we = 0; in_csr_num = '0; in_csr_wmask = '0;
        in_csr_wvalue = '0; in_ex = '0; in_ertn = 0; rf_stall = 0; csr_rvalue = '0;
    endtask

    task automatic set_entry(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                             input logic [31:0] result, input logic [2:0] ex, input logic ertn);
        in_valid = 1; in_pc = pc; in_gr_we = gr_we; in_dest = dest; in_result = result;
        in_csr_re = 0; in_csr_we = 0; in_csr_num = '0; in_csr_wmask = '0; in_csr_wvalue = '0;
        in_ex = ex; in_ertn = ertn;
    endtask

    task automatic rand_inputs();
        in_valid      = ($urandom_range(0, 9) < 7);
        in_pc         = $urandom;
        in_gr_we      = 1'($urandom);
        in_dest       = 5'($urandom);
        in_result     = $urandom;
        in_csr_re     = ($urandom_range(0, 3) == 0);
        in_csr_we     = ($urandom_range(0, 3) == 0);
        in_csr_num    = 14'($urandom);
        in_csr_wmask  = $urandom;
        in_csr_wvalue = $urandom;
        in_ex         = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        in_ertn       = ($urandom_range(0, 9) == 0);
        rf_stall      = ($urandom_range(0, 9) < 3);
        csr_rvalue    = $urandom;
    endtask

    // Inputs are already applied (just after a falling edge). Compare the
    // DUT against the model, advance the model across the coming rising
    // edge, then return on the next falling edge.
    task automatic step();
        int          sz;
        bit          ret, exc, accept;
        logic [5:0]  ecode;
        ent_t        h;
        ent_t        n;
        #1;
        sz     = q.size();
        ret    = (sz != 0) && !rf_stall;
        exc    = 0;
        h      = '{default: '0};
        if (sz != 0) begin
            h   = q[0];
            exc = (h.ex != 3'b000);
        end
        ecode = 6'h00;
        if (ret && exc) begin
            if (h.ex[0])      ecode = 6'h0B;
            else if (h.ex[1]) ecode = 6'h0C;
            else              ecode = 6'h0D;
        end
        accept = in_valid && ((sz < DEPTH) || ret);

        check("occupancy",  64'(occupancy),  64'(sz));
        check("in_allowin", 64'(in_allowin), 64'((sz < DEPTH) || ret));
        check("rf_we",      64'(rf_we),      64'(ret && h.gr_we && !exc));
        check("csr_re",     64'(csr_re),     64'(ret && h.csr_re && !exc));
        check("csr_we",     64'(csr_we),     64'(ret && h.csr_we && !exc));
        check("wb_ex",      64'(wb_ex),      64'(ret && exc));
        check("ertn_flush", 64'(ertn_flush), 64'(ret && h.ertn && !exc));
        check("wb_ecode",   64'(wb_ecode),   64'(ecode));
        check("wb_esubcode", 64'(wb_esubcode), 64'(0));
        check("debug_rf_we", 64'(debug_wb_rf_we), 64'({4{ret && h.gr_we && !exc}}));
        if (sz != 0) begin
            check("wb_pc",      64'(wb_pc),      64'(h.pc));
            check("rf_waddr",   64'(rf_waddr),   64'(h.dest));
            check("rf_wdata",   64'(rf_wdata),   64'(h.csr_re ? csr_rvalue : h.result));
            check("csr_num",    64'(csr_num),    64'(h.csr_num));
            check("csr_wmask",  64'(csr_wmask),  64'(h.wmask));
            check("csr_wvalue", 64'(csr_wvalue), 64'(h.wvalue));
            check("debug_pc",   64'(debug_wb_pc), 64'(h.pc));
            check("debug_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
            check("debug_wdata", 64'(debug_wb_rf_wdata), 64'(h.csr_re ? csr_rvalue : h.result));
        end

        if (ret && (exc || h.ertn)) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (accept) begin
                n.pc = in_pc; n.gr_we = in_gr_we; n.dest = in_dest; n.result = in_result;
                n.csr_re = in_csr_re; n.csr_we = in_csr_we; n.csr_num = in_csr_num;
                n.wmask = in_csr_wmask; n.wvalue = in_csr_wvalue; n.ex = in_ex; n.ertn = in_ertn;
                q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_rf_we",     64'(rf_we),     64'(0));
        check("rst_wb_ex",     64'(wb_ex),     64'(0));
        resetn = 1;
        @(negedge clk);

        // Single entry retires one cycle after push
        set_entry(32'h1c000000, 1, 5'd4, 32'h55, 3'b000, 0);
        step();
        clear_inputs();
        step();
        step();

        // Stall with three push attempts, then drain in order
        rf_stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_entry(32'h1c000100 + 32'(i * 4), 1, 5'(i + 1), 32'h100 + 32'(i), 3'b000, 0);
            step();
        end
        clear_inputs();
        for (int i = 0; i < 3; i++) step();

        // Full buffer with simultaneous push and retire across several cycles
        rf_stall = 1;
        for (int i = 0; i < 2; i++) begin
            set_entry(32'h1c000200 + 32'(i * 4), 1, 5'(i + 8), 32'h200 + 32'(i), 3'b000, 0);
            step();
        end
        rf_stall = 0;
        for (int i = 0; i < 5; i++) begin
            set_entry(32'h1c000300 + 32'(i * 4), 1, 5'(i + 16), 32'h300 + 32'(i), 3'b000, 0);
            step();
        end
        clear_inputs();
        repeat (3) step();

        // Exception head (sys+brk) with a younger entry queued
        rf_stall = 1;
        set_entry(32'h1c000400, 1, 5'd3, 32'h400, 3'b011, 0);
        step();
        set_entry(32'h1c000404, 1, 5'd5, 32'h404, 3'b000, 0);
        step();
        clear_inputs();
        step();
        step();

        // ertn head with a coincident push that must be discarded
        rf_stall = 1;
        set_entry(32'h1c000500, 0, 5'd0, 32'h0, 3'b000, 1);
        step();
        rf_stall = 0;
        set_entry(32'h1c000504, 1, 5'd6, 32'h504, 3'b000, 0);
        step();
        clear_inputs();
        step();

        // CSR read forwards csr_rvalue onto the GPR write data
        set_entry(32'h1c000600, 1, 5'd7, 32'h0, 3'b000, 0);
        in_csr_re = 1;
        in_csr_num = 14'h005;
        step();
        clear_inputs();
        csr_rvalue = 32'hABCD;
        step();

        // Asynchronous reset mid-stream
        rf_stall = 1;
        set_entry(32'h1c000700, 1, 5'd9, 32'h700, 3'b000, 0);
        step();
        set_entry(32'h1c000704, 1, 5'd10, 32'h704, 3'b000, 0);
        step();
        #2 resetn = 0;
        #1;
        check("async_rst_occupancy", 64'(occupancy),  64'(0));
        check("async_rst_rf_we",     64'(rf_we),      64'(0));
        check("async_rst_allowin",   64'(in_allowin), 64'(1));
        q.delete();
        clear_inputs();
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
